// File: rtl/fnn_weight_loader.sv
// Configuration-stream sequencer driving the neuron weight/bias load bus.
// Optional bias word per record when CFG_BIAS_EN is defined.
module fnn_weight_loader #(
  parameter int MAX_WEIGHTS = 784,
  parameter int LAYER_W     = 8,
  parameter int NEURON_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        weightValid,
  output logic        biasValid,
  output logic [31:0] weightValue,
  output logic [31:0] biasValue,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic        busy,
  output logic        config_done,
  output logic        cfg_error
);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    WGT  = 2'd1,
`ifdef CFG_BIAS_EN
    BIAS = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t state, state_d;

  // Counter spans the full 16-bit field so oversize records can be skipped.
  logic [15:0] cnt, cnt_d;
  logic        skip;
  logic        xfer;
  logic [15:0] hdr_n;
  logic        hdr_ok;
  logic        last_wgt;

  assign s_ready  = (state != DONE);
  assign xfer     = s_valid & s_ready;
  assign hdr_n    = s_data[15:0];
  assign hdr_ok   = (hdr_n != 16'd0) &&
                    (hdr_n <= 16'(MAX_WEIGHTS));
  assign last_wgt = (cnt == 16'd1);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      HDR: begin
        if (xfer) begin
          cnt_d   = hdr_n;
          state_d = (hdr_n == 16'd0) ? DONE : WGT;
        end
      end
      WGT: begin
        if (xfer) begin
          cnt_d = cnt - 16'd1;
          if (last_wgt) begin
`ifdef CFG_BIAS_EN
            state_d = BIAS;
`else
            state_d = HDR;
`endif
          end
        end
      end
`ifdef CFG_BIAS_EN
      BIAS: begin
        if (xfer) state_d = HDR;
      end
`endif
      DONE: state_d = HDR;
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= HDR;
      cnt               <= '0;
      skip              <= 1'b0;
      weightValid       <= 1'b0;
      weightValue       <= '0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      busy              <= 1'b0;
      config_done       <= 1'b0;
      cfg_error         <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      weightValid <= 1'b0;
      config_done <= 1'b0;
      if (state == HDR && xfer) begin
        if (hdr_n == 16'd0) begin
          config_done <= 1'b1;
        end else if (hdr_ok) begin
          config_layer_num  <=
            32'(s_data[24 +: LAYER_W]);
          config_neuron_num <=
            32'(s_data[16 +: NEURON_W]);
          busy <= 1'b1;
          skip <= 1'b0;
        end else begin
          cfg_error <= 1'b1;
          skip      <= 1'b1;
        end
      end
      if (state == WGT && xfer) begin
        if (!skip) begin
          weightValid <= 1'b1;
          weightValue <= s_data;
        end
`ifndef CFG_BIAS_EN
        if (last_wgt) busy <= 1'b0;
`endif
      end
`ifdef CFG_BIAS_EN
      if (state == BIAS && xfer) busy <= 1'b0;
`endif
    end
  end

`ifdef CFG_BIAS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      biasValid <= 1'b0;
      biasValue <= '0;
    end else begin
      biasValid <= 1'b0;
      if (state == BIAS && xfer && !skip) begin
        biasValid <= 1'b1;
        biasValue <= s_data;
      end
    end
  end
`else
  assign biasValid = 1'b0;
  assign biasValue = '0;
`endif

endmodule

// File: tb/tb_fnn_weight_loader.sv
// Directed self-checking bench for fnn_weight_loader.
// Bias checks follow CFG_BIAS_EN.
module tb_fnn_weight_loader;

  localparam int MAXW = 784;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        weightValid;
  logic        biasValid;
  logic [31:0] weightValue;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic        busy;
  logic        config_done;
  logic        cfg_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fnn_weight_loader #(
    .MAX_WEIGHTS(MAXW),
    .LAYER_W(8),
    .NEURON_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .weightValid(weightValid),
    .biasValid(biasValid),
    .weightValue(weightValue),
    .biasValue(biasValue),
    .config_layer_num(config_layer_num),
    .config_neuron_num(config_neuron_num),
    .busy(busy),
    .config_done(config_done),
    .cfg_error(cfg_error)
  );

  function automatic logic [31:0] hdr(
    input int l, input int n, input int cnt
  );
    return {8'(l), 8'(n), 16'(cnt)};
  endfunction

  // Present one word, wait for s_ready (bounded), transfer it.
  task automatic send(input logic [31:0] w);
    int guard;
    s_valid = 1'b1;
    s_data  = w;
    guard   = 0;
    while (!s_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (!s_ready) begin
      errors++;
      $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_data  = 32'hDEAD_BEEF;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, weightValid, biasValid, busy,
         config_done, cfg_error} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 100000",
               {s_ready, weightValid, biasValid, busy,
                config_done, cfg_error});
    end
    checks++;
    if ({weightValue, biasValue, config_layer_num,
         config_neuron_num} !== 128'd0) begin
      errors++;
      $display("FAIL reset_values: got %h required 0",
               {weightValue, biasValue, config_layer_num,
                config_neuron_num});
    end
    rst = 1'b0;
  endtask

  task automatic test_record;
    logic [31:0] w [3];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
    send(hdr(2, 21, 3));
    checks++;
    if (config_layer_num !== 32'd2 ||
        config_neuron_num !== 32'd21) begin
      errors++;
      $display("FAIL rec_nums: got %0d/%0d required 2/21",
               config_layer_num, config_neuron_num);
    end
    checks++;
    if (busy !== 1'b1 || weightValid !== 1'b0) begin
      errors++;
      $display("FAIL rec_hdr_busy: busy=%b wv=%b required 1/0",
               busy, weightValid);
    end
    for (int i = 0; i < 3; i++) begin
      send(w[i]);
      checks++;
      if (weightValid !== 1'b1 || weightValue !== w[i]) begin
        errors++;
        $display("FAIL rec_wgt%0d: wv=%b val=%h required 1/%h",
                 i, weightValid, weightValue, w[i]);
      end
      checks++;
      if (config_layer_num !== 32'd2 ||
          config_neuron_num !== 32'd21) begin
        errors++;
        $display("FAIL rec_nums_w%0d: got %0d/%0d required 2/21",
                 i, config_layer_num, config_neuron_num);
      end
    end
`ifdef CFG_BIAS_EN
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rec_busy_prebias: got %b required 1", busy);
    end
    send(32'hF89D);
    checks++;
    if (biasValid !== 1'b1 || biasValue !== 32'hF89D ||
        weightValid !== 1'b0) begin
      errors++;
      $display("FAIL rec_bias: bv=%b val=%h wv=%b required 1/f89d/0",
               biasValid, biasValue, weightValid);
    end
    checks++;
    if (config_layer_num !== 32'd2 ||
        config_neuron_num !== 32'd21 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rec_bias_nums: %0d/%0d busy=%b required 2/21/0",
               config_layer_num, config_neuron_num, busy);
    end
`else
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rec_busy_end: got %b required 0", busy);
    end
`endif
    idle(1);
    checks++;
    if (weightValid !== 1'b0 || biasValid !== 1'b0 ||
        weightValue !== 32'h33 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rec_idle: wv=%b bv=%b val=%h busy=%b required 0/0/33/0",
               weightValid, biasValid, weightValue, busy);
    end
`ifndef CFG_BIAS_EN
    checks++;
    if (biasValue !== 32'd0) begin
      errors++;
      $display("FAIL rec_bias_tied: got %h required 0", biasValue);
    end
`endif
  endtask

  task automatic test_gaps;
    logic [5:0]  pat;
    logic [31:0] vals [6];
    int strobes;
    int k;
    pat = 6'b101001;
    vals[0] = 32'hA1; vals[3] = 32'hA2; vals[5] = 32'hA3;
    strobes = 0;
    k = 0;
    send(hdr(1, 5, 3));
    for (int i = 0; i < 6; i++) begin
      s_valid = pat[i];
      s_data  = pat[i] ? vals[i] : 32'hDEAD_0000;
      @(posedge clk); #1;
      if (weightValid) strobes++;
      checks++;
      if (weightValid !== pat[i] ||
          (pat[i] && weightValue !== vals[i])) begin
        errors++;
        $display("FAIL gap_cyc%0d: wv=%b val=%h required %b/%h",
                 i, weightValid, weightValue, pat[i], vals[i]);
      end
      k++;
    end
`ifdef CFG_BIAS_EN
    send(32'hB0);
`endif
    idle(1);
    checks++;
    if (strobes != 3 || k != 6) begin
      errors++;
      $display("FAIL gap_count: got %0d strobes required 3", strobes);
    end
  endtask

  task automatic test_done;
    int low;
    send(hdr(0, 0, 0));
    checks++;
    if (config_done !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b rdy=%b required 1/0",
               config_done, s_ready);
    end
    low = 1;
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (!s_ready) low++;
      checks++;
      if (config_done !== 1'b0) begin
        errors++;
        $display("FAIL done_once%0d: got %b required 0",
                 i, config_done);
      end
    end
    checks++;
    if (low != 1) begin
      errors++;
      $display("FAIL done_ready_low: got %0d cycles required 1", low);
    end
    send(hdr(3, 7, 1));
    send(32'h55);
    checks++;
    if (config_layer_num !== 32'd3 || config_neuron_num !== 32'd7 ||
        weightValid !== 1'b1 || weightValue !== 32'h55) begin
      errors++;
      $display("FAIL done_next: %0d/%0d wv=%b val=%h required 3/7/1/55",
               config_layer_num, config_neuron_num,
               weightValid, weightValue);
    end
`ifdef CFG_BIAS_EN
    send(32'hB1);
`endif
    idle(1);
  endtask

  task automatic test_error;
    int strobes;
    strobes = 0;
    send(hdr(9, 9, MAXW + 1));
    checks++;
    if (cfg_error !== 1'b1 || busy !== 1'b0 ||
        config_layer_num !== 32'd3) begin
      errors++;
      $display("FAIL err_hdr: err=%b busy=%b layer=%0d required 1/0/3",
               cfg_error, busy, config_layer_num);
    end
    for (int i = 0; i < MAXW + 1; i++) begin
      send(32'h1000 + i);
      if (weightValid) strobes++;
    end
`ifdef CFG_BIAS_EN
    send(32'hBAD);
    if (biasValid) strobes++;
`endif
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL err_strobes: got %0d required 0", strobes);
    end
    send(hdr(4, 8, 2));
    send(32'h77);
    send(32'h88);
    checks++;
    if (config_layer_num !== 32'd4 || config_neuron_num !== 32'd8 ||
        weightValid !== 1'b1 || weightValue !== 32'h88) begin
      errors++;
      $display("FAIL err_next: %0d/%0d wv=%b val=%h required 4/8/1/88",
               config_layer_num, config_neuron_num,
               weightValid, weightValue);
    end
`ifdef CFG_BIAS_EN
    send(32'hB2);
`endif
    idle(2);
    checks++;
    if (cfg_error !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b required 1", cfg_error);
    end
  endtask

  task automatic test_reset_mid;
    send(hdr(5, 6, 5));
    send(32'hC1);
    send(32'hC2);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({s_ready, weightValid, busy, cfg_error} !== 4'b1000 ||
        config_layer_num !== 32'd0 || weightValue !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid: flags=%b layer=%0d val=%h required 1000/0/0",
               {s_ready, weightValid, busy, cfg_error},
               config_layer_num, weightValue);
    end
    send(hdr(6, 10, 1));
    checks++;
    if (config_layer_num !== 32'd6 || config_neuron_num !== 32'd10 ||
        weightValid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_hdr: %0d/%0d wv=%b busy=%b required 6/10/0/1",
               config_layer_num, config_neuron_num, weightValid, busy);
    end
    send(32'h99);
    checks++;
    if (weightValid !== 1'b1 || weightValue !== 32'h99) begin
      errors++;
      $display("FAIL rst_wgt: wv=%b val=%h required 1/99",
               weightValid, weightValue);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_record();
    test_gaps();
    test_done();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
